irq_priority_mux: RTL and testbench

Four-input priority selector for the interrupt controller path. Each cycle it resolves the pending interrupt status lines to a single winner: a 2-bit select, a valid flag, and the winner's vector taken from a 4:1 vector mux. It also drives a one-hot clear pulse back to the winner's status register on acknowledge. It sits between the per-line interrupt status registers and the CPU's IRQ/IACK/ADDR interface.

---
 rtl/irq_pkg.sv | 17 +
 rtl/irq_priority_mux_prio_enc4.sv | 27 ++
 rtl/irq_priority_mux.sv | 76 +++++++
 tb/tb_irq_priority_mux.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared constants and types for the interrupt priority path.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package irq_pkg;

    localparam int NUM_IRQ = 4;
    localparam int SEL_W   = 2;

    // Reset-time vector table for the four interrupt lines
    localparam logic [31:0] IRQ_VEC0 = 32'h0000_0000;
    localparam logic [31:0] IRQ_VEC1 = 32'h0000_0020;
    localparam logic [31:0] IRQ_VEC2 = 32'h0000_0040;
    localparam logic [31:0] IRQ_VEC3 = 32'h0000_0060;

    typedef logic [SEL_W-1:0] irq_sel_t;

endpackage

// File: rtl/irq_priority_mux_prio_enc4.sv
// Fixed-priority 4->2 encoder, lowest index wins, with any-request flag.
// Latency: combinational.
// Backpressure: none; pure function of req.
module prio_enc4
    import irq_pkg::*;
(
    input  logic [NUM_IRQ-1:0] req,
    output irq_sel_t           sel,
    output logic               valid
);

    // Lowest set bit wins; an empty request vector encodes as index 0
    always_comb begin
        sel   = 2'd0;
        valid = |req;
        if (req[0]) begin
            sel = 2'd0;
        end else if (req[1]) begin
            sel = 2'd1;
        end else if (req[2]) begin
            sel = 2'd2;
        end else if (req[3]) begin
            sel = 2'd3;
        end
    end

endmodule

// File: rtl/irq_priority_mux.sv
// Resolves pending interrupt lines to one registered winner (sel/valid/y) and
// a one-hot acknowledge clear. Optional per-line mask under IRQ_MASK_EN.
// Latency: 1 clock pending/vec -> sel/valid/y; 0 clocks ack -> clear. No backpressure.
module irq_priority_mux
    import irq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] pending,
    input  logic [WIDTH-1:0]   vec0,
    input  logic [WIDTH-1:0]   vec1,
    input  logic [WIDTH-1:0]   vec2,
    input  logic [WIDTH-1:0]   vec3,
    input  logic               ack,
`ifdef IRQ_MASK_EN
    input  logic [NUM_IRQ-1:0] mask,
`endif
    output logic [SEL_W-1:0]   sel,
    output logic               valid,
    output logic [WIDTH-1:0]   y,
    output logic [NUM_IRQ-1:0] clear
);

    logic [NUM_IRQ-1:0] elig;
    irq_sel_t           sel_n;
    logic               valid_n;
    logic [WIDTH-1:0]   y_n;

`ifdef IRQ_MASK_EN
    assign elig = pending & mask;
`else
    assign elig = pending;
`endif

    prio_enc4 u_enc (
        .req   (elig),
        .sel   (sel_n),
        .valid (valid_n)
    );

    // Vector mux: every select value maps to its own input
    always_comb begin
        y_n = vec0;
        case (sel_n)
            2'd0:    y_n = vec0;
            2'd1:    y_n = vec1;
            2'd2:    y_n = vec2;
            2'd3:    y_n = vec3;
            default: y_n = vec0;
        endcase
    end

    // Winner registers load unconditionally every cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel   <= '0;
            valid <= 1'b0;
            y     <= '0;
        end else begin
            sel   <= sel_n;
            valid <= valid_n;
            y     <= y_n;
        end
    end

    // Clear targets the registered winner, so a line rising alongside ack is untouched
    always_comb begin
        clear = '0;
        if (ack && valid) begin
            clear = 4'b0001 << sel;
        end
    end

endmodule

// File: tb/tb_irq_priority_mux.sv
// Directed self-checking bench for irq_priority_mux (mask tests under IRQ_MASK_EN).
// Inputs change 1 time unit after the rising edge; outputs sampled 1 unit after it.
// Summary line reports check and failure counts.
module tb_irq_priority_mux;
    import irq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  pending;
    logic [31:0] vec0, vec1, vec2, vec3;
    logic        ack;
`ifdef IRQ_MASK_EN
    logic [3:0]  mask;
`endif
    logic [1:0]  sel;
    logic        valid;
    logic [31:0] y;
    logic [3:0]  clear;

    int checks   = 0;
    int failures = 0;

    irq_priority_mux #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .pending (pending),
        .vec0    (vec0),
        .vec1    (vec1),
        .vec2    (vec2),
        .vec3    (vec3),
        .ack     (ack),
`ifdef IRQ_MASK_EN
        .mask    (mask),
`endif
        .sel     (sel),
        .valid   (valid),
        .y       (y),
        .clear   (clear)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        pending = 4'b0000;
        ack     = 1'b1;
        vec0 = IRQ_VEC0; vec1 = IRQ_VEC1; vec2 = IRQ_VEC2; vec3 = IRQ_VEC3;
`ifdef IRQ_MASK_EN
        mask = 4'b1111;
`endif
        #2;
        checks++;
        if ({valid, sel, y, clear} !== {1'b0, 2'd0, 32'h0, 4'b0000}) begin
            failures++;
            $display("FAIL reset_state got valid=%0b sel=%0d y=%h clear=%b want 0/0/0/0000",
                     valid, sel, y, clear);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++;
        if ({valid, sel, y, clear} !== {1'b0, 2'd0, 32'h0, 4'b0000}) begin
            failures++;
            $display("FAIL idle_after_reset got valid=%0b sel=%0d y=%h clear=%b want 0/0/0/0000",
                     valid, sel, y, clear);
        end
        ack = 1'b0;
    endtask

    task automatic test_priority();
        logic [3:0]  pat [8]   = '{4'b1100, 4'b1000, 4'b0001, 4'b0010,
                                   4'b1111, 4'b0110, 4'b1010, 4'b0100};
        logic [1:0]  esel [8]  = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd0, 2'd1, 2'd1, 2'd2};
        logic [31:0] ey_a [8]  = '{32'h40, 32'h60, 32'h00, 32'h20,
                                   32'h00, 32'h20, 32'h20, 32'h40};
        logic [31:0] ey_b [8]  = '{32'hC3C3_0002, 32'h8000_0003, 32'hA5A5_0000, 32'h1234_0001,
                                   32'hA5A5_0000, 32'h1234_0001, 32'h1234_0001, 32'hC3C3_0002};
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) begin
                vec0 = 32'hA5A5_0000; vec1 = 32'h1234_0001;
                vec2 = 32'hC3C3_0002; vec3 = 32'h8000_0003;
            end
            for (int i = 0; i < 8; i++) begin
                pending = pat[i];
                tick();
                checks++;
                if ({valid, sel, y} !== {1'b1, esel[i], (pass == 0) ? ey_a[i] : ey_b[i]}) begin
                    failures++;
                    $display("FAIL prio pass=%0d pending=%b got valid=%0b sel=%0d y=%h want 1/%0d/%h",
                             pass, pat[i], valid, sel, y, esel[i],
                             (pass == 0) ? ey_a[i] : ey_b[i]);
                end
            end
        end
    endtask

    task automatic test_no_eligible();
        vec0 = 32'hDEAD_BEEF;
        pending = 4'b0000;
        ack = 1'b1;
        tick();
        checks++;
        if ({valid, sel, y, clear} !== {1'b0, 2'd0, 32'hDEAD_BEEF, 4'b0000}) begin
            failures++;
            $display("FAIL no_elig got valid=%0b sel=%0d y=%h clear=%b want 0/0/deadbeef/0000",
                     valid, sel, y, clear);
        end
        ack = 1'b0;
        vec0 = IRQ_VEC0; vec1 = IRQ_VEC1; vec2 = IRQ_VEC2; vec3 = IRQ_VEC3;
    endtask

    task automatic test_ack_clear();
        pending = 4'b0100;
        tick();
        checks++;
        if ({valid, sel, clear} !== {1'b1, 2'd2, 4'b0000}) begin
            failures++;
            $display("FAIL ack_setup got valid=%0b sel=%0d clear=%b want 1/2/0000", valid, sel, clear);
        end
        ack = 1'b1;
        #1;
        checks++;
        if (clear !== 4'b0100) begin
            failures++;
            $display("FAIL ack_clear got clear=%b want 0100", clear);
        end
        @(negedge clk);
        ack = 1'b0;
        pending = 4'b1000;
        #1;
        checks++;
        if (clear !== 4'b0000) begin
            failures++;
            $display("FAIL ack_drop got clear=%b want 0000", clear);
        end
        tick();
        checks++;
        if ({valid, sel, y} !== {1'b1, 2'd3, 32'h60}) begin
            failures++;
            $display("FAIL next_winner got valid=%0b sel=%0d y=%h want 1/3/60", valid, sel, y);
        end
    endtask

    task automatic test_ack_simultaneous();
        pending = 4'b1000;
        tick();
        ack = 1'b1;
        pending = 4'b1001;
        #1;
        checks++;
        if (clear !== 4'b1000) begin
            failures++;
            $display("FAIL simul_clear got clear=%b want 1000", clear);
        end
        tick();
        ack = 1'b0;
        #1;
        checks++;
        if ({valid, sel, y} !== {1'b1, 2'd0, 32'h00}) begin
            failures++;
            $display("FAIL simul_next got valid=%0b sel=%0d y=%h want 1/0/00", valid, sel, y);
        end
        ack = 1'b1;
        #1;
        checks++;
        if (clear !== 4'b0001) begin
            failures++;
            $display("FAIL simul_clear0 got clear=%b want 0001", clear);
        end
        ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        pending = 4'b0010;
        tick();
        ack = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({valid, sel, y, clear} !== {1'b0, 2'd0, 32'h0, 4'b0000}) begin
            failures++;
            $display("FAIL reset_mid got valid=%0b sel=%0d y=%h clear=%b want 0/0/0/0000",
                     valid, sel, y, clear);
        end
        @(negedge clk);
        rst = 1'b0;
        ack = 1'b0;
        tick();
        checks++;
        if ({valid, sel, y} !== {1'b1, 2'd1, 32'h20}) begin
            failures++;
            $display("FAIL after_reset got valid=%0b sel=%0d y=%h want 1/1/20", valid, sel, y);
        end
    endtask

`ifdef IRQ_MASK_EN
    task automatic test_mask();
        mask = 4'b1110;
        pending = 4'b0011;
        tick();
        checks++;
        if ({valid, sel, y} !== {1'b1, 2'd1, 32'h20}) begin
            failures++;
            $display("FAIL mask_1110 got valid=%0b sel=%0d y=%h want 1/1/20", valid, sel, y);
        end
        mask = 4'b0000;
        pending = 4'b1111;
        tick();
        checks++;
        if ({valid, sel} !== {1'b0, 2'd0}) begin
            failures++;
            $display("FAIL mask_0000 got valid=%0b sel=%0d want 0/0", valid, sel);
        end
        mask = 4'b1111;
    endtask
`endif

    initial begin
        test_reset();
        test_priority();
        test_no_eligible();
        test_ack_clear();
        test_ack_simultaneous();
        test_reset_mid();
`ifdef IRQ_MASK_EN
        test_mask();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
